elevator_car_controller: RTL and testbench

Sequencing controller for a single elevator car serving floors 0 to FLOORS-1. It latches floor requests into a pending-stop queue and decides the travel direction at each stop. It times floor-to-floor travel and door dwell, and clears each request when the car services its floor. It sits between the merged hall/car call inputs and the car's motion/door actuators, and it is the owner of `current_floor` and `queue_status` for the rest of the car logic.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elevator_timer.sv | 42 ++++
 rtl/elevator_car_controller.sv | 147 ++++++++++++++
 tb/tb_elevator_car_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller.
//   car_state_t : IDLE / MOVING / DOOR_OPEN sequencing states
//   UP / DOWN   : encodings of the up_ndown direction bit
//   floor_w()   : width of a floor index for a given floor count
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVING    = 2'd1,
      DOOR_OPEN = 2'd2
   } car_state_t;

   localparam logic UP   = 1'b1;
   localparam logic DOWN = 1'b0;

   // A single-floor building still needs a 1-bit index.
   function automatic int unsigned floor_w(input int unsigned floors);
      return (floors > 1) ? $clog2(floors) : 1;
   endfunction

endpackage

// File: rtl/elevator_timer.sv
// Interval timer counting 0..CYCLES-1, used for travel and door dwell.
//   clk, rst : clock, synchronous active-high reset
//   start    : interval active; while low the count is held at zero
//   reload   : restart the current interval from zero
//   done_c   : terminal-count pulse (suppressed on a reload cycle)
module elevator_timer #(
   parameter int unsigned CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic reload,
   output logic done_c
);

   localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Count while active; wrap to zero at terminal so back-to-back intervals abut.
   always_comb begin
      count_d = '0;
      done_c  = 1'b0;
      if (start && !reload) begin
         if (count_q == LAST) begin
            done_c = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/elevator_car_controller.sv
// Single-car sequencing controller: latches floor calls, chooses direction
// when stationary, times travel and door dwell, clears serviced calls.
//   clk, rst      : clock, synchronous active-high reset
//   call_req      : per-floor request pulses (multi-hot allowed)
//   door_hold     : keeps the door open while high in DOOR_OPEN
//   current_floor : floor the car is at or last passed
//   up_ndown      : committed direction, 1 = up
//   moving        : car is travelling
//   door_open     : door is open
//   queue_status  : pending-stop bitmap
//   queue_empty   : no pending stops
module elevator_car_controller
   import elevator_pkg::*;
#(
   parameter int unsigned FLOORS        = 7,
   parameter int unsigned TRAVEL_CYCLES = 8,
   parameter int unsigned DOOR_CYCLES   = 4,
   localparam int unsigned FLOOR_W      = floor_w(FLOORS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FLOORS-1:0]  call_req,
   input  logic               door_hold,
   output logic [FLOOR_W-1:0] current_floor,
   output logic               up_ndown,
   output logic               moving,
   output logic               door_open,
   output logic [FLOORS-1:0]  queue_status,
   output logic               queue_empty
);

   car_state_t         state_q, state_d;
   logic [FLOOR_W-1:0] floor_q, floor_d, floor_step;
   logic               dir_q, dir_d, dir_pick;
   logic [FLOORS-1:0]  queue_q, queue_d, q_eff, above_m, below_m, clear_m;
   logic               up_any, down_any, ahead, behind;
   logic               travel_done, door_done, door_reload;
   logic               moving_q, door_q, empty_q;

   elevator_timer #(.CYCLES(TRAVEL_CYCLES)) u_travel_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (state_q == MOVING),
      .reload (1'b0),
      .done_c (travel_done)
   );

   // A same-floor call or an obstruction restarts the dwell.
   assign door_reload = (state_q == DOOR_OPEN) && (call_req[floor_q] || door_hold);

   elevator_timer #(.CYCLES(DOOR_CYCLES)) u_door_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (state_q == DOOR_OPEN),
      .reload (door_reload),
      .done_c (door_done)
   );

   // Requests strictly above / below the car, and the resulting direction choice.
   always_comb begin
      q_eff = queue_q | call_req;
      for (int i = 0; i < FLOORS; i++) begin
         above_m[i] = FLOOR_W'(i) > floor_q;
         below_m[i] = FLOOR_W'(i) < floor_q;
      end
      up_any     = |(q_eff & above_m);
      down_any   = |(q_eff & below_m);
      ahead      = (dir_q == UP) ? up_any : down_any;
      behind     = (dir_q == UP) ? down_any : up_any;
      dir_pick   = ahead ? dir_q : (behind ? ~dir_q : dir_q);
      floor_step = (dir_q == DOWN) ? (floor_q - FLOOR_W'(1)) : (floor_q + FLOOR_W'(1));
   end

   // Next-state, floor, direction and serviced-call mask.
   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      dir_d   = dir_q;
      clear_m = '0;
      case (state_q)
         IDLE: begin
            if (q_eff[floor_q]) begin
               clear_m[floor_q] = 1'b1;
               state_d          = DOOR_OPEN;
            end else if (ahead || behind) begin
               dir_d   = dir_pick;
               state_d = MOVING;
            end
         end
         MOVING: begin
            if (travel_done) begin
               floor_d = floor_step;
               if (q_eff[floor_step]) begin
                  clear_m[floor_step] = 1'b1;
                  state_d             = DOOR_OPEN;
               end
            end
         end
         DOOR_OPEN: begin
            clear_m[floor_q] = 1'b1;
            if (door_done) begin
               if (ahead || behind) begin
                  dir_d   = dir_pick;
                  state_d = MOVING;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      queue_d = q_eff & ~clear_m;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         floor_q  <= '0;
         dir_q    <= UP;
         queue_q  <= '0;
         moving_q <= 1'b0;
         door_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         dir_q    <= dir_d;
         queue_q  <= queue_d;
         moving_q <= (state_d == MOVING);
         door_q   <= (state_d == DOOR_OPEN);
         empty_q  <= (queue_d == '0);
      end
   end

   // The car only travels toward a pending request, so it never steps off either end.
   assert property (@(posedge clk) disable iff (rst)
      (state_q == MOVING && travel_done) |->
         ((dir_q == UP) ? (floor_q != FLOOR_W'(FLOORS - 1)) : (floor_q != '0)));

   assign current_floor = floor_q;
   assign up_ndown      = dir_q;
   assign moving        = moving_q;
   assign door_open     = door_q;
   assign queue_status  = queue_q;
   assign queue_empty   = empty_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed bench for elevator_car_controller (FLOORS=7, TRAVEL=4, DOOR=3).
// Expectations are queued with a due cycle when stimulus is applied and
// checked when that cycle's outputs are sampled, 1 time unit after the edge.
module tb_elevator_car_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] call_req;
   logic       door_hold;
   logic [2:0] current_floor;
   logic       up_ndown, moving, door_open, queue_empty;
   logic [6:0] queue_status;

   typedef enum int {S_FLOOR, S_DIR, S_MOV, S_DOOR, S_QUEUE, S_EMPTY} sig_t;
   typedef struct {
      int         due;
      string      tag;
      sig_t       sig;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   elevator_car_controller #(
      .FLOORS        (7),
      .TRAVEL_CYCLES (4),
      .DOOR_CYCLES   (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .call_req      (call_req),
      .door_hold     (door_hold),
      .current_floor (current_floor),
      .up_ndown      (up_ndown),
      .moving        (moving),
      .door_open     (door_open),
      .queue_status  (queue_status),
      .queue_empty   (queue_empty)
   );

   function automatic logic [7:0] observe(input sig_t s);
      case (s)
         S_FLOOR: return 8'(current_floor);
         S_DIR:   return 8'(up_ndown);
         S_MOV:   return 8'(moving);
         S_DOOR:  return 8'(door_open);
         S_QUEUE: return 8'(queue_status);
         default: return 8'(queue_empty);
      endcase
   endfunction

   task automatic exp_at(input int dt, input string tag, input sig_t s, input logic [7:0] v);
      exp_t e;
      e.due = cyc + dt;
      e.tag = tag;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic exp_all(input int dt, input string tag, input logic [2:0] fl, input logic dir,
                          input logic mov, input logic door, input logic [6:0] q);
      exp_at(dt, {tag, "_floor"}, S_FLOOR, 8'(fl));
      exp_at(dt, {tag, "_dir"},   S_DIR,   8'(dir));
      exp_at(dt, {tag, "_mov"},   S_MOV,   8'(mov));
      exp_at(dt, {tag, "_door"},  S_DOOR,  8'(door));
      exp_at(dt, {tag, "_queue"}, S_QUEUE, 8'(q));
      exp_at(dt, {tag, "_empty"}, S_EMPTY, 8'(q == 7'd0));
   endtask

   task automatic check_due();
      exp_t       keep[$];
      exp_t       e;
      logic [7:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.due <= cyc) begin
            n_tests++;
            obs = observe(e.sig);
            assert (obs === e.val) else begin
               n_fail++;
               $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", e.tag, cyc, obs, e.val);
            end
         end else begin
            keep.push_back(e);
         end
      end
      sb = keep;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      check_due();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      rst       = 1'b1;
      call_req  = '0;
      door_hold = 1'b0;

      // Reset state
      step();
      exp_all(1, "reset", 3'd0, 1'b1, 1'b0, 1'b0, 7'd0);
      step();
      rst = 1'b0;

      // Single trip 0 -> 3
      call_req = 7'b0001000;
      exp_at(1,  "trip_mov_start",  S_MOV,   8'd1);
      exp_at(1,  "trip_q_latched",  S_QUEUE, 8'b0001000);
      exp_at(1,  "trip_not_empty",  S_EMPTY, 8'd0);
      exp_at(4,  "trip_floor0_hold",S_FLOOR, 8'd0);
      exp_at(5,  "trip_floor1",     S_FLOOR, 8'd1);
      exp_at(9,  "trip_floor2",     S_FLOOR, 8'd2);
      exp_at(12, "trip_door_early", S_DOOR,  8'd0);
      exp_at(13, "trip_floor3",     S_FLOOR, 8'd3);
      exp_at(13, "trip_door_open",  S_DOOR,  8'd1);
      exp_at(13, "trip_q_cleared",  S_QUEUE, 8'd0);
      exp_at(15, "trip_door_last",  S_DOOR,  8'd1);
      exp_all(16, "trip_idle", 3'd3, 1'b1, 1'b0, 1'b0, 7'd0);
      step();
      call_req = '0;
      steps(15);

      // Same-floor call at floor 3
      call_req = 7'b0001000;
      exp_at(1, "same_door",    S_DOOR,  8'd1);
      exp_at(1, "same_queue",   S_QUEUE, 8'd0);
      exp_at(1, "same_mov",     S_MOV,   8'd0);
      exp_at(3, "same_door_end",S_DOOR,  8'd1);
      exp_at(4, "same_closed",  S_DOOR,  8'd0);
      step();
      call_req = '0;
      steps(3);

      // Reopen: a same-floor call during dwell restarts the timer
      call_req = 7'b0001000;
      exp_at(1, "reopen_door",     S_DOOR,  8'd1);
      exp_at(3, "reopen_queue",    S_QUEUE, 8'd0);
      exp_at(4, "reopen_extended", S_DOOR,  8'd1);
      exp_at(5, "reopen_last",     S_DOOR,  8'd1);
      exp_at(6, "reopen_closed",   S_DOOR,  8'd0);
      step();
      call_req = '0;
      step();
      call_req = 7'b0001000;
      step();
      call_req = '0;
      steps(3);

      // Dwell extension: hold for 5 cycles starting at door-open
      call_req = 7'b0001000;
      exp_at(7, "hold_door7",  S_DOOR, 8'd1);
      exp_at(8, "hold_door8",  S_DOOR, 8'd1);
      exp_at(9, "hold_closed", S_DOOR, 8'd0);
      step();
      call_req  = '0;
      door_hold = 1'b1;
      steps(5);
      door_hold = 1'b0;
      steps(3);

      // Sweep priority: going 3 -> 5, floor 1 called behind the car
      call_req = 7'b0100000;
      exp_at(3,  "sweep_q_both",    S_QUEUE, 8'b0100010);
      exp_at(5,  "sweep_floor4",    S_FLOOR, 8'd4);
      exp_at(5,  "sweep_pass4",     S_DOOR,  8'd0);
      exp_at(9,  "sweep_floor5",    S_FLOOR, 8'd5);
      exp_at(9,  "sweep_door5",     S_DOOR,  8'd1);
      exp_at(9,  "sweep_q_after5",  S_QUEUE, 8'b0000010);
      exp_at(11, "sweep_dir_up",    S_DIR,   8'd1);
      exp_at(12, "sweep_dir_down",  S_DIR,   8'd0);
      exp_at(12, "sweep_mov_nogap", S_MOV,   8'd1);
      exp_at(16, "sweep_back4",     S_FLOOR, 8'd4);
      exp_at(20, "sweep_pass3",     S_DOOR,  8'd0);
      exp_at(28, "sweep_floor1",    S_FLOOR, 8'd1);
      exp_at(28, "sweep_door1",     S_DOOR,  8'd1);
      exp_at(28, "sweep_empty",     S_EMPTY, 8'd1);
      exp_all(31, "sweep_idle", 3'd1, 1'b0, 1'b0, 1'b0, 7'd0);
      step();
      call_req = '0;
      step();
      call_req = 7'b0000010;
      step();
      call_req = '0;
      steps(28);

      // Reset while moving at floor 4 with queue 1000001
      call_req = 7'b1000000;
      exp_at(1,  "rstmid_dir_up", S_DIR,   8'd1);
      exp_at(13, "rstmid_floor4", S_FLOOR, 8'd4);
      exp_at(15, "rstmid_queue",  S_QUEUE, 8'b1000001);
      exp_at(15, "rstmid_moving", S_MOV,   8'd1);
      exp_all(16, "rstmid", 3'd0, 1'b1, 1'b0, 1'b0, 7'd0);
      step();
      call_req = '0;
      steps(13);
      call_req = 7'b0000001;
      step();
      call_req = '0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      step();

      // Same-floor call at floor 0 after reset
      call_req = 7'b0000001;
      exp_at(1, "f0_door",   S_DOOR,  8'd1);
      exp_at(1, "f0_queue",  S_QUEUE, 8'd0);
      exp_at(1, "f0_empty",  S_EMPTY, 8'd1);
      exp_at(4, "f0_closed", S_DOOR,  8'd0);
      step();
      call_req = '0;
      steps(4);

      // Any expectation never reached counts as a failure.
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: never checked (due cycle %0d, expected 0x%0h)", e.tag, e.due, e.val);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
